// File: rtl/sal_bank_arbiter.sv
// sal_bank_arbiter: inter-bank command arbiter between per-bank FSMs and the
// DFI command path. It issues at most one grant per cycle and picks the command
// class by priority: PRE > RD > WR > ACT > REF. Inside a class, banks are served
// round-robin from one shared pointer. The arbiter also enforces the DDR2
// inter-bank spacings tRRD, tCCD, tWTR and tRTW.
//
// Optional feature macro: SAL_SCHED_TFAW_EN. When it is defined, the arbiter
// also enforces the tFAW rule: at most 4 ACT grants in any rolling TFAW-cycle
// window.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   act/rd/wr/pre/ref_req per-bank requests, held until granted
//   act/rd/wr/pre/ref_gnt one-hot grants, combinational (zero latency)
//   gnt_valid            a grant is issued this cycle
//   gnt_bk               granted bank index (0 when no grant)
//   gnt_cmd              0 none, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF
module sal_bank_arbiter #(
  parameter int unsigned BK_CNT = 8,
  parameter int unsigned TRRD   = 2,
  parameter int unsigned TCCD   = 2,
  parameter int unsigned TWTR   = 3,
  parameter int unsigned TRTW   = 4,
  parameter int unsigned TFAW   = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [BK_CNT-1:0]         act_req,
  input  logic [BK_CNT-1:0]         rd_req,
  input  logic [BK_CNT-1:0]         wr_req,
  input  logic [BK_CNT-1:0]         pre_req,
  input  logic [BK_CNT-1:0]         ref_req,
  output logic [BK_CNT-1:0]         act_gnt,
  output logic [BK_CNT-1:0]         rd_gnt,
  output logic [BK_CNT-1:0]         wr_gnt,
  output logic [BK_CNT-1:0]         pre_gnt,
  output logic [BK_CNT-1:0]         ref_gnt,
  output logic                      gnt_valid,
  output logic [$clog2(BK_CNT)-1:0] gnt_bk,
  output logic [2:0]                gnt_cmd
);

  localparam int unsigned BK_W  = $clog2(BK_CNT);
  localparam int unsigned ACT_W = $clog2(TRRD + 1);
  localparam int unsigned CAS_W = $clog2(TCCD + 1);
  localparam int unsigned WTR_W = $clog2(TWTR + 1);
  localparam int unsigned RTW_W = $clog2(TRTW + 1);

  typedef enum logic [2:0] {
    CMD_NONE = 3'd0,
    CMD_ACT  = 3'd1,
    CMD_RD   = 3'd2,
    CMD_WR   = 3'd3,
    CMD_PRE  = 3'd4,
    CMD_REF  = 3'd5
  } cmd_e;

  logic [ACT_W-1:0]  act_cnt;
  logic [CAS_W-1:0]  cas_cnt;
  logic [WTR_W-1:0]  wtr_cnt;
  logic [RTW_W-1:0]  rtw_cnt;
  logic [BK_W-1:0]   rr_ptr;

  logic              act_ok;
  logic              faw_ok;
  logic              rd_ok;
  logic              wr_ok;
  cmd_e              sel_cmd;
  logic [BK_CNT-1:0] sel_req;
  logic              found;
  logic [BK_W-1:0]   sel_bk;
  logic [BK_W-1:0]   scan_idx;
  logic [BK_CNT-1:0] gnt_hot;
  logic              is_act;
  logic              is_rd;
  logic              is_wr;

`ifdef SAL_SCHED_TFAW_EN
  localparam int unsigned FAW_W = $clog2(TFAW + 1);

  logic [FAW_W-1:0] faw_slot [4];
  logic             faw_free;
  logic [1:0]       faw_load_idx;

  // Lowest-index idle slot takes the next ACT. ACT is blocked while none is idle.
  always_comb begin
    faw_free     = 1'b0;
    faw_load_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (faw_slot[i] == '0) begin
        faw_free     = 1'b1;
        faw_load_idx = 2'(i);
      end
    end
  end

  assign faw_ok = faw_free;

  // Rolling tFAW window slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) faw_slot[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (is_act && faw_load_idx == 2'(i)) begin
          faw_slot[i] <= FAW_W'(TFAW - 1);
        end else if (faw_slot[i] != '0) begin
          faw_slot[i] <= faw_slot[i] - FAW_W'(1);
        end
      end
    end
  end
`else
  // TFAW has no effect in this build.
  logic tfaw_unused;
  assign tfaw_unused = ^TFAW;
  assign faw_ok      = 1'b1;
`endif

  assign rd_ok  = (cas_cnt == '0) && (wtr_cnt == '0);
  assign wr_ok  = (cas_cnt == '0) && (rtw_cnt == '0);
  assign act_ok = (act_cnt == '0) && faw_ok;

  // Class selection: the highest-priority class that is both requested and timing-eligible.
  always_comb begin
    sel_cmd = CMD_NONE;
    sel_req = '0;
    if (!rst) begin
      if (|pre_req) begin
        sel_cmd = CMD_PRE;
        sel_req = pre_req;
      end else if ((|rd_req) && rd_ok) begin
        sel_cmd = CMD_RD;
        sel_req = rd_req;
      end else if ((|wr_req) && wr_ok) begin
        sel_cmd = CMD_WR;
        sel_req = wr_req;
      end else if ((|act_req) && act_ok) begin
        sel_cmd = CMD_ACT;
        sel_req = act_req;
      end else if (|ref_req) begin
        sel_cmd = CMD_REF;
        sel_req = ref_req;
      end
    end
  end

  // Round-robin: first requesting bank at or after rr_ptr. The index wraps
  // naturally because BK_CNT is a power of two.
  always_comb begin
    found    = 1'b0;
    sel_bk   = '0;
    scan_idx = '0;
    for (int i = 0; i < BK_CNT; i++) begin
      scan_idx = rr_ptr + BK_W'(i);
      if (!found && sel_req[scan_idx]) begin
        found  = 1'b1;
        sel_bk = scan_idx;
      end
    end
  end

  // Grant fan-out into the per-class one-hot vectors.
  always_comb begin
    gnt_hot   = found ? (BK_CNT'(1) << sel_bk) : '0;
    act_gnt   = (sel_cmd == CMD_ACT) ? gnt_hot : '0;
    rd_gnt    = (sel_cmd == CMD_RD)  ? gnt_hot : '0;
    wr_gnt    = (sel_cmd == CMD_WR)  ? gnt_hot : '0;
    pre_gnt   = (sel_cmd == CMD_PRE) ? gnt_hot : '0;
    ref_gnt   = (sel_cmd == CMD_REF) ? gnt_hot : '0;
    gnt_valid = found;
    gnt_bk    = sel_bk;
    gnt_cmd   = found ? sel_cmd : CMD_NONE;
  end

  assign is_act = found && (sel_cmd == CMD_ACT);
  assign is_rd  = found && (sel_cmd == CMD_RD);
  assign is_wr  = found && (sel_cmd == CMD_WR);

  // Spacing counters. A load on grant takes priority over the saturating decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_cnt <= '0;
      cas_cnt <= '0;
      wtr_cnt <= '0;
      rtw_cnt <= '0;
      rr_ptr  <= '0;
    end else begin
      if (is_act)              act_cnt <= ACT_W'(TRRD - 1);
      else if (act_cnt != '0)  act_cnt <= act_cnt - ACT_W'(1);

      if (is_rd || is_wr)      cas_cnt <= CAS_W'(TCCD - 1);
      else if (cas_cnt != '0)  cas_cnt <= cas_cnt - CAS_W'(1);

      if (is_wr)               wtr_cnt <= WTR_W'(TWTR - 1);
      else if (wtr_cnt != '0)  wtr_cnt <= wtr_cnt - WTR_W'(1);

      if (is_rd)               rtw_cnt <= RTW_W'(TRTW - 1);
      else if (rtw_cnt != '0)  rtw_cnt <= rtw_cnt - RTW_W'(1);

      if (found)               rr_ptr  <= sel_bk + BK_W'(1);
    end
  end

endmodule

// File: tb/tb_sal_bank_arbiter.sv
// Self-checking bench for sal_bank_arbiter. The reference model keeps the
// absolute cycle time of the most recent grant of each kind, plus a list of ACT
// times. Eligibility comes from the elapsed cycles since those grants.
module tb_sal_bank_arbiter;
  localparam int BK   = 8;
  localparam int TRRD = 2;
  localparam int TCCD = 2;
  localparam int TWTR = 3;
  localparam int TRTW = 4;
  localparam int TFAW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [BK-1:0] act_req = '0, rd_req = '0, wr_req = '0, pre_req = '0, ref_req = '0;
  logic [BK-1:0] act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
  logic          gnt_valid;
  logic [2:0]    gnt_bk;
  logic [2:0]    gnt_cmd;

  sal_bank_arbiter #(
    .BK_CNT(BK), .TRRD(TRRD), .TCCD(TCCD), .TWTR(TWTR), .TRTW(TRTW), .TFAW(TFAW)
  ) dut (
    .clk(clk), .rst(rst),
    .act_req(act_req), .rd_req(rd_req), .wr_req(wr_req), .pre_req(pre_req), .ref_req(ref_req),
    .act_gnt(act_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt), .pre_gnt(pre_gnt), .ref_gnt(ref_gnt),
    .gnt_valid(gnt_valid), .gnt_bk(gnt_bk), .gnt_cmd(gnt_cmd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Pending requests, each held until the model says it was granted.
  logic [BK-1:0] p_act = '0, p_rd = '0, p_wr = '0, p_pre = '0, p_ref = '0;

  // Reference model state.
  longint cyc = 0;
  longint last_act = -1000, last_cas = -1000, last_rd = -1000, last_wr = -1000;
  longint faw_q[$];
  int     ptr = 0;

  // DUT outputs captured at the most recent compare point.
  logic [BK-1:0] c_act, c_rd, c_wr, c_pre, c_ref;
  logic          c_valid;
  logic [2:0]    c_bk, c_cmd;

  function automatic bit faw_ok();
`ifdef SAL_SCHED_TFAW_EN
    int n = 0;
    foreach (faw_q[i]) if (cyc - faw_q[i] < TFAW) n++;
    return n < 4;
`else
    return 1'b1;
`endif
  endfunction

  function automatic void model(input bit r, output int cmd, output int bk);
    logic [BK-1:0] v;
    bit            hit;
    v   = '0;
    cmd = 0;
    bk  = 0;
    hit = 0;
    if (!r) begin
      if (p_pre != 0) begin
        cmd = 4; v = p_pre;
      end else if (p_rd != 0 && cyc - last_cas >= TCCD && cyc - last_wr >= TWTR) begin
        cmd = 2; v = p_rd;
      end else if (p_wr != 0 && cyc - last_cas >= TCCD && cyc - last_rd >= TRTW) begin
        cmd = 3; v = p_wr;
      end else if (p_act != 0 && cyc - last_act >= TRRD && faw_ok()) begin
        cmd = 1; v = p_act;
      end else if (p_ref != 0) begin
        cmd = 5; v = p_ref;
      end
      for (int k = 0; k < BK; k++) begin
        if (!hit && v[(ptr + k) % BK]) begin
          hit = 1;
          bk  = (ptr + k) % BK;
        end
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v === exp_v) passed++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act_v, exp_v, cyc);
  endtask

  // Runs one clock cycle: drive the inputs, compare every output with the model,
  // then advance the model across the clock edge.
  task automatic step(input bit r);
    int            cmd, bk;
    logic [BK-1:0] hot;
    logic [BK*5+7-1:0] exp_b, got_b;
    rst = r;
    act_req = p_act; rd_req = p_rd; wr_req = p_wr; pre_req = p_pre; ref_req = p_ref;
    @(negedge clk);
    model(r, cmd, bk);
    hot = (cmd != 0) ? (BK'(1) << bk) : '0;
    exp_b = {(cmd == 1) ? hot : 8'h0, (cmd == 2) ? hot : 8'h0, (cmd == 3) ? hot : 8'h0,
             (cmd == 4) ? hot : 8'h0, (cmd == 5) ? hot : 8'h0,
             1'(cmd != 0), 3'(bk), 3'(cmd)};
    got_b = {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt, gnt_valid, gnt_bk, gnt_cmd};
    checks++;
    if (got_b === exp_b) passed++;
    else $display("FAIL model_cmp: got %h, expected %h (cycle %0d)", got_b, exp_b, cyc);
    c_act = act_gnt; c_rd = rd_gnt; c_wr = wr_gnt; c_pre = pre_gnt; c_ref = ref_gnt;
    c_valid = gnt_valid; c_bk = gnt_bk; c_cmd = gnt_cmd;
    @(posedge clk);
    #1;
    if (r) begin
      last_act = -1000; last_cas = -1000; last_rd = -1000; last_wr = -1000;
      faw_q.delete();
      ptr = 0;
    end else if (cmd != 0) begin
      case (cmd)
        1: begin p_act[bk] = 1'b0; last_act = cyc; faw_q.push_back(cyc); end
        2: begin p_rd[bk]  = 1'b0; last_cas = cyc; last_rd = cyc; end
        3: begin p_wr[bk]  = 1'b0; last_cas = cyc; last_wr = cyc; end
        4: p_pre[bk] = 1'b0;
        default: p_ref[bk] = 1'b0;
      endcase
      ptr = (bk + 1) % BK;
    end
    cyc++;
  endtask

  initial begin
    @(posedge clk);
    #1;

    // Reset state.
    step(1'b1);
    chk("rst_valid", 32'(c_valid), 32'd0);
    chk("rst_cmd",   32'(c_cmd),   32'd0);

    // All banks request PRE: served 0..7, one per cycle.
    p_pre = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      step(1'b0);
      chk("pre_sweep_gnt", 32'(c_pre), 32'(8'h01 << i));
      chk("pre_sweep_cmd", 32'(c_cmd), 32'd4);
    end

    // Class priority: PRE, then RD, then ACT, with the pointer wrapped.
    p_pre[3] = 1'b1; p_rd[5] = 1'b1; p_act[1] = 1'b1;
    step(1'b0); chk("prio_pre", 32'(c_pre), 32'h08);
    step(1'b0); chk("prio_rd",  32'(c_rd),  32'h20);
    step(1'b0); chk("prio_act", 32'(c_act), 32'h02);

    // tRRD = 2.
    step(1'b1);
    p_act = 8'h03;
    step(1'b0); chk("trrd_0", 32'(c_act),   32'h01);
    step(1'b0); chk("trrd_1", 32'(c_valid), 32'd0);
    step(1'b0); chk("trrd_2", 32'(c_act),   32'h02);

    // tWTR = 3: RD three cycles after WR.
    step(1'b1);
    p_wr[2] = 1'b1;
    step(1'b0); chk("wtr_wr", 32'(c_wr), 32'h04);
    p_rd[4] = 1'b1;
    step(1'b0); chk("wtr_gap1", 32'(c_valid), 32'd0);
    step(1'b0); chk("wtr_gap2", 32'(c_valid), 32'd0);
    step(1'b0); chk("wtr_rd", 32'(c_rd), 32'h10);

    // tRTW = 4: WR four cycles after RD.
    step(1'b1);
    p_rd[0] = 1'b1;
    step(1'b0); chk("rtw_rd", 32'(c_rd), 32'h01);
    p_wr[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      chk("rtw_gap", 32'(c_valid), 32'd0);
    end
    step(1'b0); chk("rtw_wr", 32'(c_wr), 32'h02);

    // Reset right after WR clears the pending spacing.
    step(1'b1);
    p_wr[2] = 1'b1;
    step(1'b0); chk("rstmid_wr", 32'(c_wr), 32'h04);
    p_rd[4] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b1);
      chk("rstmid_valid", 32'(c_valid), 32'd0);
      chk("rstmid_bk",    32'(c_bk),    32'd0);
    end
    step(1'b0); chk("rstmid_rd", 32'(c_rd), 32'h10);

    // Randomized traffic, with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < BK; b++) begin
        if ($urandom_range(0, 11) == 0) p_act[b] = 1'b1;
        if ($urandom_range(0, 11) == 0) p_rd[b]  = 1'b1;
        if ($urandom_range(0, 11) == 0) p_wr[b]  = 1'b1;
        if ($urandom_range(0, 23) == 0) p_pre[b] = 1'b1;
        if ($urandom_range(0, 23) == 0) p_ref[b] = 1'b1;
      end
      step($urandom_range(0, 99) == 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
